// File: rtl/io_int_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// io_int_ctrl_pkg : register addresses and FSM encoding for io_int_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package io_int_ctrl_pkg;

  localparam logic [13:0] SYS_INT_PEND  = 14'h3E81;
  localparam logic [13:0] SYS_INT_ENAB  = 14'h3E82;
  localparam logic [13:0] SYS_INT_CAUSE = 14'h3E83;
  localparam logic [13:0] SYS_INT_MODE  = 14'h3E84;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SRV  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/io_int_sync.sv
// ---------------------------------------------------------------------------
// io_int_sync : multi-bit flop synchronizer; rising-edge output when
//               INT_EDGE_MODE_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_int_sync
  import io_int_ctrl_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
`ifdef INT_EDGE_MODE_EN
  ,
  output logic [WIDTH-1:0] rise_o
`endif
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];

`ifdef INT_EDGE_MODE_EN
  logic [WIDTH-1:0] sync_d_q;

  always_ff @(posedge clk) begin
    if (rst) sync_d_q <= '0;
    else     sync_d_q <= sync_q[STAGES-1];
  end

  assign rise_o = sync_q[STAGES-1] & ~sync_d_q;
`endif

endmodule

`default_nettype wire

// File: rtl/io_int_ctrl.sv
// ---------------------------------------------------------------------------
// io_int_ctrl : machine-level interrupt controller (timer + NSRC external).
// Optional macro INT_EDGE_MODE_EN adds per-source edge mode (SYS_INT_MODE).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module io_int_ctrl
  import io_int_ctrl_pkg::*;
#(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dma_io_we,
  input  logic [15:2]     dma_io_wadr,
  input  logic [31:0]     dma_io_wdata,
  input  logic [15:2]     dma_io_radr,
  input  logic            dma_io_radr_en,
  input  logic [31:0]     dma_io_rdata_in,
  output logic [31:0]     dma_io_rdata,
  input  logic            frc_cntr_val_leq,
  input  logic            interrupt_clear,
  input  logic [NSRC-1:0] ext_int_in,
  input  logic            csr_mie,
  input  logic            int_ack,
  input  logic            int_mret,
  output logic            int_req,
  output logic [3:0]      int_cause
);

  localparam int N = NSRC + 1;

  logic [NSRC-1:0] ext_sync;
  logic [N-1:0]    lvl, set, clr, masked;
  logic [N-1:0]    pend_q, pend_d, enab_q;
  logic [15:0]     masked_ext;
  logic [3:0]      prio;
  logic            pend_wr;
  state_e          state_q, state_d;
  logic [3:0]      cause_q, cause_d;
  logic            rd_hit_q, rd_hit_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            unused_wdata;

  assign unused_wdata = ^dma_io_wdata[31:N];

`ifdef INT_EDGE_MODE_EN
  logic [NSRC-1:0] ext_rise;
  logic [N-1:0]    mode_q;
  logic            leq_d_q;

  io_int_sync #(.WIDTH(NSRC), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_int_in),
    .sync_o  (ext_sync),
    .rise_o  (ext_rise)
  );

  assign lvl = {ext_sync, frc_cntr_val_leq};
  assign set = (lvl & ~mode_q) | ({ext_rise, frc_cntr_val_leq & ~leq_d_q} & mode_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      leq_d_q <= 1'b0;
    end else begin
      leq_d_q <= frc_cntr_val_leq;
      if (dma_io_we && (dma_io_wadr == SYS_INT_MODE)) mode_q <= dma_io_wdata[N-1:0];
    end
  end
`else
  io_int_sync #(.WIDTH(NSRC), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ext_int_in),
    .sync_o  (ext_sync)
  );

  assign lvl = {ext_sync, frc_cntr_val_leq};
  assign set = lvl;
`endif

  // Set is OR'd in after the clear so a coincident event is never lost.
  assign pend_wr = dma_io_we && (dma_io_wadr == SYS_INT_PEND);
  assign clr     = (pend_wr ? dma_io_wdata[N-1:0] : '0) | {{(N-1){1'b0}}, interrupt_clear};
  assign pend_d  = (pend_q & ~clr) | set;

  assign masked     = pend_q & enab_q;
  assign masked_ext = 16'(masked);

  always_comb begin
    prio = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) prio = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (csr_mie && (|masked)) begin
          state_d = ST_REQ;
          cause_d = prio;
        end
      end
      ST_REQ: begin
        if (int_ack)                     state_d = ST_SRV;
        else if (!masked_ext[cause_q])   state_d = ST_IDLE;
      end
      ST_SRV: begin
        if (int_mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_hit_d  = 1'b0;
    rd_data_d = '0;
    if (dma_io_radr_en) begin
      case (dma_io_radr)
        SYS_INT_PEND: begin
          rd_hit_d  = 1'b1;
          rd_data_d = 32'(pend_q);
        end
        SYS_INT_ENAB: begin
          rd_hit_d  = 1'b1;
          rd_data_d = 32'(enab_q);
        end
        SYS_INT_CAUSE: begin
          rd_hit_d  = 1'b1;
          rd_data_d = {state_q == ST_SRV, state_q == ST_REQ, 26'd0, cause_q};
        end
`ifdef INT_EDGE_MODE_EN
        SYS_INT_MODE: begin
          rd_hit_d  = 1'b1;
          rd_data_d = 32'(mode_q);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      enab_q    <= '0;
      state_q   <= ST_IDLE;
      cause_q   <= 4'd0;
      rd_hit_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      pend_q    <= pend_d;
      state_q   <= state_d;
      cause_q   <= cause_d;
      rd_hit_q  <= rd_hit_d;
      rd_data_q <= rd_data_d;
      if (dma_io_we && (dma_io_wadr == SYS_INT_ENAB)) enab_q <= dma_io_wdata[N-1:0];
    end
  end

  assign int_req      = (state_q == ST_REQ);
  assign int_cause    = cause_q;
  assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;

endmodule

`default_nettype wire

// File: tb/tb_io_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_io_int_ctrl : self-checking bench for io_int_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_io_int_ctrl;
  import io_int_ctrl_pkg::*;

  localparam int NSRC = 4;
  localparam int SYNC = 2;
  localparam int N    = NSRC + 1;
  localparam logic [13:0] UNMAPPED = 14'h3E90;

  logic            clk = 1'b0;
  logic            rst;
  logic            dma_io_we;
  logic [13:0]     dma_io_wadr;
  logic [31:0]     dma_io_wdata;
  logic [13:0]     dma_io_radr;
  logic            dma_io_radr_en;
  logic [31:0]     dma_io_rdata_in;
  logic [31:0]     dma_io_rdata;
  logic            frc_cntr_val_leq;
  logic            interrupt_clear;
  logic [NSRC-1:0] ext_int_in;
  logic            csr_mie;
  logic            int_ack;
  logic            int_mret;
  logic            int_req;
  logic [3:0]      int_cause;

  int checks = 0;
  int errors = 0;

  io_int_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SYNC)) dut (
    .clk              (clk),
    .rst              (rst),
    .dma_io_we        (dma_io_we),
    .dma_io_wadr      (dma_io_wadr),
    .dma_io_wdata     (dma_io_wdata),
    .dma_io_radr      (dma_io_radr),
    .dma_io_radr_en   (dma_io_radr_en),
    .dma_io_rdata_in  (dma_io_rdata_in),
    .dma_io_rdata     (dma_io_rdata),
    .frc_cntr_val_leq (frc_cntr_val_leq),
    .interrupt_clear  (interrupt_clear),
    .ext_int_in       (ext_int_in),
    .csr_mie          (csr_mie),
    .int_ack          (int_ack),
    .int_mret         (int_mret),
    .int_req          (int_req),
    .int_cause        (int_cause)
  );

  always #5 clk = ~clk;

  // Behavioural reference: pending/enable sets, a plain delay line for the
  // synchronizer, and a 3-phase handshake (0 idle, 1 requesting, 2 servicing).
  logic [N-1:0]    m_pend, m_enab, m_mode, m_prev_lvl;
  logic [NSRC-1:0] m_hist [SYNC];
  int              m_phase;
  logic [3:0]      m_cause;
  bit              m_hit;
  logic [31:0]     m_rdata;

  function automatic logic [3:0] lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] masked, lvl, setv, clr;
    if (rst) begin
      m_pend = '0; m_enab = '0; m_mode = '0; m_prev_lvl = '0;
      for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
      m_phase = 0; m_cause = 4'd0; m_hit = 0; m_rdata = '0;
      return;
    end
    masked  = m_pend & m_enab;
    m_hit   = 0;
    m_rdata = '0;
    if (dma_io_radr_en) begin
      if (dma_io_radr == SYS_INT_PEND) begin m_hit = 1; m_rdata = 32'(m_pend); end
      if (dma_io_radr == SYS_INT_ENAB) begin m_hit = 1; m_rdata = 32'(m_enab); end
      if (dma_io_radr == SYS_INT_CAUSE) begin
        m_hit = 1;
        m_rdata = 32'(m_cause);
        m_rdata[31] = (m_phase == 2);
        m_rdata[30] = (m_phase == 1);
      end
`ifdef INT_EDGE_MODE_EN
      if (dma_io_radr == SYS_INT_MODE) begin m_hit = 1; m_rdata = 32'(m_mode); end
`endif
    end
    lvl  = {m_hist[SYNC-1], frc_cntr_val_leq};
    setv = lvl;
`ifdef INT_EDGE_MODE_EN
    for (int i = 0; i < N; i++) if (m_mode[i]) setv[i] = lvl[i] && !m_prev_lvl[i];
`endif
    m_prev_lvl = lvl;
    clr = '0;
    if (dma_io_we && dma_io_wadr == SYS_INT_PEND) clr = dma_io_wdata[N-1:0];
    if (interrupt_clear) clr[0] = 1'b1;
    m_pend = (m_pend & ~clr) | setv;
    if (dma_io_we && dma_io_wadr == SYS_INT_ENAB) m_enab = dma_io_wdata[N-1:0];
`ifdef INT_EDGE_MODE_EN
    if (dma_io_we && dma_io_wadr == SYS_INT_MODE) m_mode = dma_io_wdata[N-1:0];
`endif
    if (m_phase == 0) begin
      if (csr_mie && masked != '0) begin m_phase = 1; m_cause = lowest(masked); end
    end else if (m_phase == 1) begin
      if (int_ack) m_phase = 2;
      else if (!masked[m_cause]) m_phase = 0;
    end else if (int_mret) begin
      m_phase = 0;
    end
    for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ext_int_in;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("model_int_req", 32'(int_req), 32'(m_phase == 1));
    chk("model_int_cause", 32'(int_cause), 32'(m_cause));
    chk("model_rdata", dma_io_rdata, m_hit ? m_rdata : dma_io_rdata_in);
  endtask

  task automatic idle();
    rst = 0; dma_io_we = 0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr = '0; dma_io_radr_en = 0; interrupt_clear = 0;
    int_ack = 0; int_mret = 0;
  endtask

  task automatic wr(logic [13:0] a, logic [31:0] d);
    dma_io_we = 1; dma_io_wadr = a; dma_io_wdata = d;
    cycle();
    dma_io_we = 0;
  endtask

  task automatic rd(logic [13:0] a);
    dma_io_radr_en = 1; dma_io_radr = a;
    cycle();
    dma_io_radr_en = 0;
  endtask

  typedef struct {
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic        re;
    logic [13:0] radr;
    logic [31:0] rdin;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [9];
  logic [13:0] addrs [5];

  initial begin
    tbl[0] = '{1, SYS_INT_ENAB, 32'hFFFF_FFFF, 0, '0, 32'h1234_5678, 32'h1234_5678, "wr_enab_passthru"};
    tbl[1] = '{0, '0, '0, 1, SYS_INT_ENAB, 32'hFFFF_FFFF, 32'h0000_001F, "rd_enab_all"};
    tbl[2] = '{0, '0, '0, 1, SYS_INT_PEND, 32'h0, 32'h0, "rd_pend_zero"};
    tbl[3] = '{0, '0, '0, 1, SYS_INT_CAUSE, 32'h0, 32'h0, "rd_cause_idle"};
    tbl[4] = '{0, '0, '0, 1, UNMAPPED, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rd_unmapped"};
`ifdef INT_EDGE_MODE_EN
    tbl[5] = '{0, '0, '0, 1, SYS_INT_MODE, 32'hA5A5_A5A5, 32'h0, "rd_mode_reset"};
`else
    tbl[5] = '{0, '0, '0, 1, SYS_INT_MODE, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "rd_mode_unmapped"};
`endif
    tbl[6] = '{1, SYS_INT_ENAB, 32'h5, 0, '0, 32'h0, 32'h0, "wr_enab_5"};
    tbl[7] = '{0, '0, '0, 1, SYS_INT_ENAB, 32'h0, 32'h5, "rd_enab_5"};
    tbl[8] = '{1, UNMAPPED, 32'hFFFF_FFFF, 1, SYS_INT_ENAB, 32'h0, 32'h5, "wr_unmapped_ignored"};
    addrs = '{SYS_INT_PEND, SYS_INT_ENAB, SYS_INT_CAUSE, SYS_INT_MODE, UNMAPPED};

    idle();
    frc_cntr_val_leq = 0; ext_int_in = '0; csr_mie = 0;
    dma_io_rdata_in = 32'hCAFE_F00D;
    rst = 1;
    cycle(); cycle();
    rst = 0;
    chk("reset_int_req", 32'(int_req), 32'h0);
    chk("reset_int_cause", 32'(int_cause), 32'h0);
    chk("reset_rdata_pass", dma_io_rdata, 32'hCAFE_F00D);

    for (int i = 0; i < 9; i++) begin
      dma_io_we = tbl[i].we; dma_io_wadr = tbl[i].wadr; dma_io_wdata = tbl[i].wdata;
      dma_io_radr_en = tbl[i].re; dma_io_radr = tbl[i].radr; dma_io_rdata_in = tbl[i].rdin;
      cycle();
      dma_io_we = 0; dma_io_radr_en = 0;
      chk(tbl[i].name, dma_io_rdata, tbl[i].exp);
    end
    dma_io_rdata_in = '0;

    // Timer path
    wr(SYS_INT_ENAB, 32'h1);
    csr_mie = 1; frc_cntr_val_leq = 1;
    cycle(); cycle();
    chk("timer_req", 32'(int_req), 32'h1);
    chk("timer_cause", 32'(int_cause), 32'h0);
    int_ack = 1; cycle(); int_ack = 0;
    chk("timer_ack_drop", 32'(int_req), 32'h0);
    frc_cntr_val_leq = 0; interrupt_clear = 1; cycle(); interrupt_clear = 0;
    rd(SYS_INT_PEND);
    chk("timer_pend_cleared", dma_io_rdata, 32'h0);
    rd(SYS_INT_CAUSE);
    chk("timer_in_service", dma_io_rdata, 32'h8000_0000);
    int_mret = 1; cycle(); int_mret = 0;
    rd(SYS_INT_CAUSE);
    chk("timer_mret_idle", dma_io_rdata, 32'h0);

    // Priority
    wr(SYS_INT_ENAB, 32'h1F);
    ext_int_in = 4'b1010;
    for (int k = 0; k < 8 && !int_req; k++) cycle();
    chk("prio_req", 32'(int_req), 32'h1);
    chk("prio_cause", 32'(int_cause), 32'h2);
    rd(SYS_INT_PEND);
    chk("prio_pend", dma_io_rdata, 32'h14);
    int_ack = 1; cycle(); int_ack = 0;
    ext_int_in = '0;
    repeat (4) cycle();
    wr(SYS_INT_PEND, 32'h1F);
    int_mret = 1; cycle(); int_mret = 0;

    // Masking and global enable
    csr_mie = 0; ext_int_in = 4'b0001;
    repeat (6) begin cycle(); chk("mie_off_no_req", 32'(int_req), 32'h0); end
    wr(SYS_INT_ENAB, 32'h0);
    csr_mie = 1;
    repeat (3) begin cycle(); chk("enab_off_no_req", 32'(int_req), 32'h0); end
    wr(SYS_INT_ENAB, 32'h1F);
    cycle();
    chk("enab_on_req", 32'(int_req), 32'h1);
    chk("enab_on_cause", 32'(int_cause), 32'h1);

    // Withdrawal before ack
    ext_int_in = '0;
    repeat (SYNC + 1) cycle();
    wr(SYS_INT_PEND, 32'h2);
    cycle();
    chk("withdraw_req_low", 32'(int_req), 32'h0);
    rd(SYS_INT_CAUSE);
    chk("withdraw_no_srv", 32'(dma_io_rdata[31:30]), 32'h0);

    // Set/clear collision
    csr_mie = 0; ext_int_in = 4'b0001;
    repeat (SYNC + 2) cycle();
    wr(SYS_INT_PEND, 32'h2);
    rd(SYS_INT_PEND);
    chk("collision_set_wins", dma_io_rdata, 32'h2);
    ext_int_in = '0;
    repeat (4) cycle();
    wr(SYS_INT_PEND, 32'h1F);
    rd(SYS_INT_PEND);
    chk("pend_w1c_all", dma_io_rdata, 32'h0);

    // Reset while requesting
    csr_mie = 1; frc_cntr_val_leq = 1;
    repeat (3) cycle();
    chk("pre_reset_req", 32'(int_req), 32'h1);
    rst = 1; cycle(); rst = 0;
    frc_cntr_val_leq = 0;
    chk("mid_reset_req", 32'(int_req), 32'h0);
    rd(SYS_INT_ENAB);
    chk("mid_reset_enab", dma_io_rdata, 32'h0);

`ifdef INT_EDGE_MODE_EN
    csr_mie = 0;
    wr(SYS_INT_MODE, 32'h2);
    ext_int_in = 4'b0001;
    repeat (6) cycle();
    rd(SYS_INT_PEND);
    chk("edge_one_set", dma_io_rdata, 32'h2);
    wr(SYS_INT_PEND, 32'h2);
    repeat (4) cycle();
    rd(SYS_INT_PEND);
    chk("edge_no_reset", dma_io_rdata, 32'h0);
    ext_int_in = '0;
    repeat (3) cycle();
`endif

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      rst              = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) ext_int_in = NSRC'($urandom);
      frc_cntr_val_leq = ($urandom_range(0, 3) == 0);
      interrupt_clear  = ($urandom_range(0, 7) == 0);
      csr_mie          = ($urandom_range(0, 7) != 0);
      int_ack          = ($urandom_range(0, 3) == 0);
      int_mret         = ($urandom_range(0, 5) == 0);
      dma_io_we        = ($urandom_range(0, 7) == 0);
      dma_io_wadr      = addrs[$urandom_range(0, 4)];
      dma_io_wdata     = $urandom;
      dma_io_radr_en   = ($urandom_range(0, 1) == 0);
      dma_io_radr      = addrs[$urandom_range(0, 4)];
      dma_io_rdata_in  = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
